// File: rtl/adc_sample_ctrl.sv
// ADC sequencing controller: divided ADC clock, sample capture on the falling
// ADC clock edge, 1/2/4/8-sample block averaging and a show-ahead result FIFO.
module adc_sample_ctrl #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        avg_log2,
    output logic              adc_clock,
    input  logic [DATA_W-1:0] adc_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              overflow,
    input  logic              clear_overflow,
    output logic              busy
);

    localparam int ACC_W = DATA_W + 3;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nx;
    logic   start;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE: if (enable) begin
                state_nx = RUN;
                start    = 1'b1;
            end
            RUN:  if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Divider and averager
    logic [DIV_W-1:0]  div_q, div_cnt;
    logic [1:0]        avg_q;
    logic [2:0]        smp_cnt, smp_last;
    logic [ACC_W-1:0]  acc, acc_sum;
    logic [DATA_W-1:0] result;
    logic              run, div_hit, sample, push;

    assign run      = (state == RUN) && enable;
    assign div_hit  = run && (div_cnt == div_q);
    assign sample   = div_hit && adc_clock;
    assign smp_last = 3'((4'd1 << avg_q) - 4'd1);
    assign acc_sum  = acc + ACC_W'(adc_data);
    assign result   = DATA_W'(acc_sum >> avg_q);
    assign push     = sample && (smp_cnt == smp_last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            avg_q     <= '0;
            div_cnt   <= '0;
            smp_cnt   <= '0;
            acc       <= '0;
            adc_clock <= 1'b0;
        end else if (!run) begin
            // Idle or leaving RUN: any partial block is discarded here.
            div_cnt   <= '0;
            smp_cnt   <= '0;
            acc       <= '0;
            adc_clock <= 1'b0;
            if (start) begin
                div_q <= div;
                avg_q <= avg_log2;
            end
        end else begin
            if (div_hit) begin
                div_cnt   <= '0;
                adc_clock <= ~adc_clock;
            end else begin
                div_cnt   <= div_cnt + DIV_W'(1);
            end
            if (sample) begin
                if (push) begin
                    acc     <= '0;
                    smp_cnt <= '0;
                end else begin
                    acc     <= acc_sum;
                    smp_cnt <= smp_cnt + 3'd1;
                end
            end
        end
    end

    // Result FIFO; pointers carry one extra wrap bit
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, pop, wr_en;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the head slot, which is the slot written.
    assign wr_en     = push && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= result;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
        else if (clear_overflow)      overflow <= 1'b0;
    end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl; inputs change on the falling clock edge
// and outputs are checked there, i.e. half a period after each rising edge.
module tb_adc_sample_ctrl;

    logic       clock = 1'b0;
    logic       reset_n, enable, out_ready, clear_overflow;
    logic [7:0] div, adc_data;
    logic [1:0] avg_log2;
    logic       adc_clock, out_valid, overflow, busy;
    logic [7:0] out_data;

    int vectors     = 0;
    int miscompares = 0;

    adc_sample_ctrl #(.DATA_W(8), .DIV_W(8), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .div(div),
        .avg_log2(avg_log2), .adc_clock(adc_clock), .adc_data(adc_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .overflow(overflow), .clear_overflow(clear_overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0; clear_overflow = 1'b0;
        div = 8'd0; avg_log2 = 2'd0; adc_data = 8'd0;
        tick(2);
        check("rst_adc_clock", adc_clock, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_overflow",  overflow,  0);
        check("rst_busy",      busy,      0);
        reset_n = 1'b1;
        tick();

        // Basic run: div=1, N=1, period 4
        div = 8'd1; avg_log2 = 2'd0; adc_data = 8'h5A; out_ready = 1'b1; enable = 1'b1;
        tick();                                   // E
        check("t1_busy_E", busy, 1);
        check("t1_clk_E", adc_clock, 0);
        tick();  check("t1_clk_E1", adc_clock, 0);
        tick();  check("t1_clk_E2", adc_clock, 1);
        tick();  check("t1_clk_E3", adc_clock, 1);
                 check("t1_valid_E3", out_valid, 0);
        tick();  check("t1_clk_E4", adc_clock, 0);
                 check("t1_valid_E4", out_valid, 1);
                 check("t1_data_E4", out_data, 8'h5A);
        tick();  check("t1_valid_E5", out_valid, 0);
        tick();  check("t1_clk_E6", adc_clock, 1);
        tick(2); check("t1_valid_E8", out_valid, 1);
                 check("t1_data_E8", out_data, 8'h5A);
        enable = 1'b0;
        tick();  check("t1_busy_off", busy, 0);
                 check("t1_clk_off", adc_clock, 0);
                 check("t1_valid_off", out_valid, 0);
        out_ready = 1'b0;

        // Averaging 4 samples with truncation: (10+20+30+41)>>2 = 0x19
        div = 8'd0; avg_log2 = 2'd2; adc_data = 8'd10; enable = 1'b1;
        tick();                                   // E
        tick();  check("t2_valid_E1", out_valid, 0);
        tick();  adc_data = 8'd20;                // E+2 took 10
        tick(2); check("t2_valid_E4", out_valid, 0);
        adc_data = 8'd30;
        tick(2); check("t2_valid_E6", out_valid, 0);
        adc_data = 8'd41;
        tick();  check("t2_valid_E7", out_valid, 0);
        tick();  check("t2_valid_E8", out_valid, 1);
                 check("t2_data_E8", out_data, 8'h19);
        enable = 1'b0;
        tick();  check("t2_kept", out_data, 8'h19);
        out_ready = 1'b1;
        tick();  check("t2_drained", out_valid, 0);
        out_ready = 1'b0;

        // Overflow: samples 1..5 with no consumer
        div = 8'd0; avg_log2 = 2'd0; enable = 1'b1;
        tick();                                   // E
        for (int k = 1; k <= 5; k++) begin
            adc_data = 8'(k);
            tick(2);
            if (k == 4) check("t3_ovf_after4", overflow, 0);
        end
        check("t3_ovf_after5", overflow, 1);
        check("t3_head", out_data, 8'd1);
        adc_data = 8'd6;
        tick();
        clear_overflow = 1'b1;                    // coincides with a new drop
        tick();
        clear_overflow = 1'b0;
        check("t3_ovf_set_wins", overflow, 1);
        enable = 1'b0;
        tick();  check("t3_ovf_sticky", overflow, 1);
        clear_overflow = 1'b1;
        tick();  check("t3_ovf_cleared", overflow, 0);
        clear_overflow = 1'b0;
        check("t3_drain0", out_data, 8'd1);
        out_ready = 1'b1;
        tick();  check("t3_drain1", out_data, 8'd2);
        tick();  check("t3_drain2", out_data, 8'd3);
        tick();  check("t3_drain3", out_data, 8'd4);
        tick();  check("t3_empty", out_valid, 0);
        out_ready = 1'b0;

        // Full with simultaneous pop on the 5th sample edge
        enable = 1'b1;
        tick();                                   // E
        for (int k = 1; k <= 4; k++) begin
            adc_data = 8'(k);
            tick(2);
        end
        adc_data = 8'd5;
        tick();
        out_ready = 1'b1;
        tick();                                   // E+10: push and pop
        out_ready = 1'b0;
        check("t4_ovf", overflow, 0);
        check("t4_head", out_data, 8'd2);
        enable = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();  check("t4_drain1", out_data, 8'd3);
        tick();  check("t4_drain2", out_data, 8'd4);
        tick();  check("t4_drain3", out_data, 8'd5);
        tick();  check("t4_empty", out_valid, 0);
        out_ready = 1'b0;

        // Disable mid-average, then re-enable with div=2
        div = 8'd0; avg_log2 = 2'd0; adc_data = 8'h77; enable = 1'b1;
        tick(3);                                  // E, E+2 pushes 0x77
        enable = 1'b0;
        tick();
        avg_log2 = 2'd3; adc_data = 8'hFF; enable = 1'b1;
        tick(11);                                 // E + 5 samples
        enable = 1'b0;
        tick();  check("t5_clk_off", adc_clock, 0);
                 check("t5_busy_off", busy, 0);
                 check("t5_fifo_kept", out_data, 8'h77);
        tick(3); check("t5_clk_idle", adc_clock, 0);
        div = 8'd2; avg_log2 = 2'd3; enable = 1'b1;
        tick();                                   // E
        div = 8'd0; avg_log2 = 2'd0;              // must be ignored while running
        tick(2); check("t5_clk_E2", adc_clock, 0);
        tick();  check("t5_clk_E3", adc_clock, 1);
        tick(2); check("t5_clk_E5", adc_clock, 1);
        tick();  check("t5_clk_E6", adc_clock, 0);
        tick(3); check("t5_clk_E9", adc_clock, 1);
        tick(9); check("t5_valid_E18", out_valid, 1);
                 check("t5_head_E18", out_data, 8'h77);
        out_ready = 1'b1;
        tick();  check("t5_no_partial", out_valid, 0);
        out_ready = 1'b0;
        tick(28); check("t5_valid_E47", out_valid, 0);
        tick();  check("t5_valid_E48", out_valid, 1);
                 check("t5_data_E48", out_data, 8'hFF);
        enable = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset between edges while running
        div = 8'd0; avg_log2 = 2'd0; adc_data = 8'h33; enable = 1'b1;
        tick(4);                                  // E+3
        check("t6_clk_pre", adc_clock, 1);
        check("t6_valid_pre", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_clk_rst", adc_clock, 0);
        check("t6_valid_rst", out_valid, 0);
        check("t6_data_rst", out_data, 0);
        check("t6_ovf_rst", overflow, 0);
        check("t6_busy_rst", busy, 0);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();  check("t6_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
